// File: rtl/div_iterative.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign correction in a dedicated cycle, results held until the EX stage releases them.
module div_iterative #(
    parameter int DIV_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               div_start,
    input  logic [DIV_WIDTH:0] div_s1,
    input  logic [DIV_WIDTH:0] div_s2,
    input  logic               ex_stall,
    input  logic               div_kill,
    output logic [DIV_WIDTH:0] div_quotient,
    output logic [DIV_WIDTH:0] div_remainder,
    output logic               div_done,
    output logic               div_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH:0]   ONE_W1  = {{DIV_WIDTH{1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH:0]   ZERO_W1 = {(DIV_WIDTH+1){1'b0}};
    localparam logic [DIV_WIDTH:0]   ONES_W1 = {(DIV_WIDTH+1){1'b1}};
    localparam logic [DIV_WIDTH-1:0] ZERO_W  = {DIV_WIDTH{1'b0}};
    localparam logic [5:0]           LAST_STEP = 6'(DIV_WIDTH - 1);

    // Two's-complement negation of a result-width value.
    function automatic logic [DIV_WIDTH:0] neg_w1(input logic [DIV_WIDTH:0] v);
        return ~v + ONE_W1;
    endfunction

    // Magnitude of a sign-extended operand; -2^31 still fits in DIV_WIDTH bits.
    function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH:0] v);
        logic [DIV_WIDTH:0] a;
        a = v[DIV_WIDTH] ? neg_w1(v) : v;
        return a[DIV_WIDTH-1:0];
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [5:0]             cnt_r;
    logic [DIV_WIDTH-1:0]   rem_r;
    logic [DIV_WIDTH-1:0]   quo_r;
    logic [DIV_WIDTH-1:0]   dmag_r;
    logic                   q_neg_r;
    logic                   r_neg_r;
    logic [DIV_WIDTH:0]     quotient_r;
    logic [DIV_WIDTH:0]     remainder_r;
    logic                   done_r;
    logic                   zero_s;
    logic [DIV_WIDTH:0]     shift_s;
    logic [DIV_WIDTH:0]     diff_s;
    logic                   ge_s;
    logic [DIV_WIDTH-1:0]   rem_step_s;
    logic [DIV_WIDTH-1:0]   quo_step_s;

    assign zero_s = (div_s2 == ZERO_W1);

    // One restoring step: quo_r doubles as the dividend shifter and quotient collector.
    always_comb begin
        shift_s    = {rem_r, quo_r[DIV_WIDTH-1]};
        diff_s     = shift_s - {1'b0, dmag_r};
        ge_s       = (shift_s >= {1'b0, dmag_r});
        rem_step_s = ge_s ? diff_s[DIV_WIDTH-1:0] : shift_s[DIV_WIDTH-1:0];
        quo_step_s = {quo_r[DIV_WIDTH-2:0], ge_s};
    end

    // Next-state logic; a kill overrides everything, including a fresh start.
    always_comb begin
        state_s = state_r;
        if (div_kill) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (div_start) begin
                        state_s = zero_s ? DONE : CALC;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == LAST_STEP) begin
                        state_s = FIX;
                    end else begin
                        state_s = CALC;
                    end
                end
                FIX:  state_s = DONE;
                DONE: begin
                    if (ex_stall) begin
                        state_s = DONE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register and registered done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_s == DONE);
        end
    end

    // Datapath: operands latched only in IDLE, results written only in FIX or on divide-by-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 6'd0;
            rem_r       <= ZERO_W;
            quo_r       <= ZERO_W;
            dmag_r      <= ZERO_W;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            quotient_r  <= ZERO_W1;
            remainder_r <= ZERO_W1;
        end else if (!div_kill) begin
            case (state_r)
                IDLE: begin
                    if (div_start) begin
                        if (zero_s) begin
                            quotient_r  <= ONES_W1;
                            remainder_r <= div_s1;
                        end else begin
                            quo_r   <= mag(div_s1);
                            rem_r   <= ZERO_W;
                            dmag_r  <= mag(div_s2);
                            q_neg_r <= div_s1[DIV_WIDTH] ^ div_s2[DIV_WIDTH];
                            r_neg_r <= div_s1[DIV_WIDTH];
                            cnt_r   <= 6'd0;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r + 6'd1;
                end
                FIX: begin
                    quotient_r  <= q_neg_r ? neg_w1({1'b0, quo_r}) : {1'b0, quo_r};
                    remainder_r <= r_neg_r ? neg_w1({1'b0, rem_r}) : {1'b0, rem_r};
                end
                default: begin
                end
            endcase
        end
    end

    assign div_quotient  = quotient_r;
    assign div_remainder = remainder_r;
    assign div_done      = done_r;
    assign div_stall     = div_start & ~done_r;

endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative: scoreboard of expected quotient/remainder
// pairs computed from native signed arithmetic, plus latency/stall/kill/reset scenarios.
module tb_div_iterative;

    logic        clk;
    logic        rst_n;
    logic        div_start;
    logic [32:0] div_s1;
    logic [32:0] div_s2;
    logic        ex_stall;
    logic        div_kill;
    logic [32:0] div_quotient;
    logic [32:0] div_remainder;
    logic        div_done;
    logic        div_stall;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q_q[$];
    logic [32:0] exp_r_q[$];

    div_iterative #(.DIV_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_start    (div_start),
        .div_s1       (div_s1),
        .div_s2       (div_s2),
        .ex_stall     (ex_stall),
        .div_kill     (div_kill),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done),
        .div_stall    (div_stall)
    );

    always #5 clk = ~clk;

    // Reference: truncating signed division on 64-bit values of the extended operands.
    function automatic void model(input logic [32:0] s1, input logic [32:0] s2,
                                  output logic [32:0] q, output logic [32:0] r);
        longint a;
        longint b;
        a = $signed(s1);
        b = $signed(s2);
        if (b == 0) begin
            q = 33'h1_FFFF_FFFF;
            r = s1;
        end else begin
            q = 33'(a / b);
            r = 33'(a % b);
        end
    endfunction

    // Drive one request (called at posedge+1) and wait for done; leaves div_start high.
    task automatic do_op(input logic [32:0] s1, input logic [32:0] s2, input int exp_edges,
                         input bit scramble, input string name, output int stall_hi);
        logic [32:0] eq;
        logic [32:0] er;
        int edges;
        bit seen;
        model(s1, s2, eq, er);
        exp_q_q.push_back(eq);
        exp_r_q.push_back(er);
        div_s1 = s1;
        div_s2 = s2;
        div_start = 1'b1;
        edges = 0;
        seen = 1'b0;
        stall_hi = 0;
        #1;
        if (div_done !== 1'b1) begin
            checks++;
            if (div_stall !== 1'b1) begin
                errors++;
                $display("FAIL %s stall_pre: got %b expected 1", name, div_stall);
            end
            stall_hi++;
        end
        while (edges < 100 && !seen) begin
            @(posedge clk);
            edges++;
            #1;
            if (scramble && edges == 1) begin
                div_s1 = {1'b0, $urandom};
                div_s2 = {1'b1, $urandom};
            end
            if (div_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (div_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL %s stall: got %b expected 1 at edge %0d", name, div_stall, edges);
                end
                stall_hi++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done never seen within %0d edges", name, edges);
        end
        checks++;
        if (edges != exp_edges) begin
            errors++;
            $display("FAIL %s latency: got %0d edges expected %0d", name, edges, exp_edges);
        end
        eq = exp_q_q.pop_front();
        er = exp_r_q.pop_front();
        checks++;
        if (div_quotient !== eq) begin
            errors++;
            $display("FAIL %s quotient: got %h expected %h", name, div_quotient, eq);
        end
        checks++;
        if (div_remainder !== er) begin
            errors++;
            $display("FAIL %s remainder: got %h expected %h", name, div_remainder, er);
        end
    endtask

    // Release the request and confirm DONE is left on the next edge.
    task automatic finish_op(input string name);
        div_start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (div_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_exit: got %b expected 0", name, div_done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (div_quotient !== 33'h0) begin
            errors++;
            $display("FAIL reset quotient: got %h expected 0", div_quotient);
        end
        checks++;
        if (div_remainder !== 33'h0) begin
            errors++;
            $display("FAIL reset remainder: got %h expected 0", div_remainder);
        end
        checks++;
        if (div_done !== 1'b0 || div_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset done_stall: got %b%b expected 00", div_done, div_stall);
        end
    endtask

    task automatic test_basic();
        int sh;
        logic [31:0] a;
        logic [31:0] b;
        do_op(33'd20, 33'd3, 34, 1'b0, "s20_3", sh);
        checks++;
        if (sh != 34) begin
            errors++;
            $display("FAIL s20_3 stall_cycles: got %0d expected 34", sh);
        end
        finish_op("s20_3");
        do_op(33'h1_FFFF_FFF9, 33'd2, 34, 1'b0, "sm7_2", sh);
        finish_op("sm7_2");
        do_op(33'h0_FFFF_FFFF, 33'd1, 34, 1'b0, "uffff_1", sh);
        finish_op("uffff_1");
        do_op(33'h1_8000_0000, 33'h1_FFFF_FFFF, 34, 1'b0, "smin_m1", sh);
        finish_op("smin_m1");
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 32'h0000_FFFF);
            if (i[0]) b = ~b;
            do_op({a[31], a}, {b[31], b}, 34, 1'b0, "rand_signed", sh);
            finish_op("rand_signed");
            do_op({1'b0, a}, {1'b0, b}, 34, 1'b0, "rand_unsigned", sh);
            finish_op("rand_unsigned");
        end
    endtask

    task automatic test_div_zero();
        int sh;
        do_op(33'd5, 33'd0, 1, 1'b0, "div0_pos", sh);
        finish_op("div0_pos");
        do_op(33'h1_FFFF_FFF9, 33'd0, 1, 1'b0, "div0_neg", sh);
        finish_op("div0_neg");
    endtask

    task automatic test_operand_change();
        int sh;
        do_op(33'd1000, 33'd7, 34, 1'b1, "operand_change", sh);
        finish_op("operand_change");
    endtask

    task automatic test_kill();
        logic [32:0] hq;
        logic [32:0] hr;
        int sh;
        hq = div_quotient;
        hr = div_remainder;
        div_s1 = 33'd100;
        div_s2 = 33'd7;
        div_start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        div_kill = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (div_done !== 1'b0 || div_quotient !== hq || div_remainder !== hr) begin
                errors++;
                $display("FAIL kill hold: got done=%b q=%h r=%h expected done=0 q=%h r=%h",
                         div_done, div_quotient, div_remainder, hq, hr);
            end
        end
        div_kill = 1'b0;
        do_op(33'd9, 33'd4, 34, 1'b0, "after_kill", sh);
        finish_op("after_kill");
    endtask

    task automatic test_back_to_back();
        logic [32:0] hq;
        logic [32:0] hr;
        int sh;
        do_op(33'd100, 33'd9, 34, 1'b0, "b2b_first", sh);
        hq = div_quotient;
        hr = div_remainder;
        ex_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (div_done !== 1'b1 || div_quotient !== hq || div_remainder !== hr) begin
                errors++;
                $display("FAIL b2b hold: got done=%b q=%h r=%h expected done=1 q=%h r=%h",
                         div_done, div_quotient, div_remainder, hq, hr);
            end
        end
        ex_stall = 1'b0;
        do_op(33'h1_FFFF_FF9C, 33'd8, 35, 1'b0, "b2b_second", sh);
        finish_op("b2b_second");
    endtask

    task automatic test_reset_mid();
        int sh;
        div_s1 = 33'd50;
        div_s2 = 33'd5;
        div_start = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (div_quotient !== 33'h0 || div_remainder !== 33'h0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got q=%h r=%h done=%b expected 0 0 0",
                     div_quotient, div_remainder, div_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(33'd50, 33'd5, 34, 1'b0, "reset_restart", sh);
        finish_op("reset_restart");
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        div_start = 1'b0;
        div_s1 = 33'h0;
        div_s2 = 33'h0;
        ex_stall = 1'b0;
        div_kill = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_div_zero();
        test_operand_change();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iterative.md
DIV_ITERATIVE -- requirements
Module: div_iterative

Interface
REQ-001 SHALL have parameter: DIV_WIDTH, 32, architectural data width; operands and results are DIV_WIDTH+1 bits wide.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: div_start  input  1  level request, high while a DIV/DIVU/REM/REMU instruction sits in EX.
REQ-005 SHALL have port: div_s1  input  33  dividend, sign-extended for signed ops, zero-extended for unsigned ops.
REQ-006 SHALL have port: div_s2  input  33  divisor, same extension rule as div_s1.
REQ-007 SHALL have port: ex_stall  input  1  EX held by another source this cycle.
REQ-008 SHALL have port: div_kill  input  1  pipeline flush of the EX instruction.
REQ-009 SHALL have port: div_quotient  output  33  two's-complement quotient, registered.
REQ-010 SHALL have port: div_remainder  output  33  two's-complement remainder, registered.
REQ-011 SHALL have port: div_done  output  1  results valid for the current request.
REQ-012 SHALL have port: div_stall  output  1  pipeline stall request, combinational: div_start AND NOT div_done.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 IDLE: on div_start=1 with div_s2 != 0, latch |div_s1|, |div_s2| (32-bit magnitudes), sign flags q_neg = s1[32] XOR s2[32], r_neg = s1[32]; clear 6-bit counter; go CALC.
REQ-015 IDLE: on div_start=1 with div_s2 == 0, load quotient = all ones (33'h1_FFFF_FFFF), remainder = div_s1; go DONE directly (no CALC/FIX).
REQ-016 CALC: one restoring step per cycle: shift {rem,dividend} left 1, trial-subtract divisor magnitude, keep difference and set quotient bit when non-negative; 32 steps, then go FIX.
REQ-017 FIX: negate magnitude quotient when q_neg, remainder when r_neg; write sign-correct 33-bit results to div_quotient/div_remainder; go DONE.
REQ-018 Latency: start sampled at edge E0; div_done high in the cycle after edge E0+33 (34 edges total); divide-by-zero: div_done high after edge E0+1.
REQ-019 DONE: div_done=1; stay DONE while ex_stall=1 (results held stable); go IDLE when ex_stall=0.
REQ-020 A div_start high in IDLE the cycle after DONE SHALL start a new operation (back-to-back divides supported).
REQ-021 div_quotient/div_remainder SHALL change only in FIX or on divide-by-zero load; held otherwise.
REQ-022 -2^31 / -1 (signed) SHALL yield quotient 33'h0_8000_0000 (low 32 bits 0x8000_0000), remainder 0, without special-casing.
REQ-023 div_kill=1 in any state SHALL force IDLE at next edge, div_done=0; outputs keep prior values; div_kill has priority over div_start.
REQ-024 div_start dropping during CALC/FIX (without div_kill) SHALL NOT abort; operation completes, DONE exits next cycle since ex_stall is irrelevant to a departed instruction only via ex_stall=0.
REQ-025 Operand inputs SHALL be sampled only in IDLE; changes during CALC/FIX ignored.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counter 0, div_quotient 0, div_remainder 0, div_done 0, internal sign flags 0, regardless of clock.
REQ-027 Reset release mid-operation SHALL not resume the aborted divide; a held div_start starts a fresh operation.

Verification
REQ-028 Signed 20 / 3 (s1=33'd20, s2=33'd3) -> q=6, r=2, div_done after edge 34, div_stall high for 34 cycles.
REQ-029 Signed -7 / 2 -> q=33'h1_FFFF_FFFD (-3), r=33'h1_FFFF_FFFF (-1).
REQ-030 Unsigned 0xFFFF_FFFF / 1 (s1=33'h0_FFFF_FFFF) -> q=33'h0_FFFF_FFFF, r=0; signed 0x8000_0000 / -1 -> q low32=0x8000_0000, r=0.
REQ-031 Divide by zero 5 / 0 -> q=33'h1_FFFF_FFFF, r=5, div_done after edge 1.
REQ-032 div_kill at CALC step 10, then new start 9/4 -> IDLE next edge, no done; new op yields q=2, r=1 after 34 edges.
REQ-033 ex_stall=1 for 3 cycles in DONE, then back-to-back second divide -> done/results held 4 cycles, second op starts the edge after exit, correct results.
